asym_buffer_fifo: RTL

ASYM_BUFFER_FIFO -- requirements
Module: asym_buffer_fifo

---
 rtl/asym_buffer_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/asym_buffer_fifo.sv
// -----------------------------------------------------------------------------
// asym_buffer_fifo
//
// Single-clock FIFO whose write and read ports have different data widths.
// Storage is an array of UNITS entries. Each entry is min(WIDTHA,WIDTHB) bits
// wide and is called a "unit". A write stores WIDTHA/minW units. A read
// fetches WIDTHB/minW units. Wide words are packed big-endian: the unit at the
// lowest address sits in the most-significant slice.
//
// Parameters:
//   WIDTHA  write-port width in bits
//   WIDTHB  read-port width in bits; the ratio of the two widths is 1,2,4 or 8
//   UNITS   depth in min-width units; a power of 2, at least 2x the ratio
//
// Ports:
//   buffer_clk       clock; all state changes on its rising edge
//   buffer_rst       synchronous active-high reset
//   buffer_we        write request, taken only while buffer_full is 0
//   buffer_din       write data, WIDTHA bits
//   buffer_re        read request, taken only while buffer_empty is 0
//   buffer_dout      registered read data, WIDTHB bits; holds between reads
//   buffer_dout_vld  one-cycle pulse the cycle after an accepted read
//   buffer_full      fewer free units than one write word needs
//   buffer_empty     fewer stored units than one read word needs
//   buffer_count     number of stored units
//   buffer_ovf       sticky: write attempted while full
//   buffer_udf       sticky: read attempted while empty
//
// Optional feature macro: ASYM_FIFO_ERR_FLAG_EN
//   When this macro is defined, buffer_ovf and buffer_udf are sticky error
//   registers that only reset clears. When it is undefined, both outputs are
//   tied to 0 and no flag registers exist.
// -----------------------------------------------------------------------------
module asym_buffer_fifo #(
  parameter int WIDTHA = 8,
  parameter int WIDTHB = 32,
  parameter int UNITS  = 256
) (
  input  logic                     buffer_clk,
  input  logic                     buffer_rst,
  input  logic                     buffer_we,
  input  logic [WIDTHA-1:0]        buffer_din,
  input  logic                     buffer_re,
  output logic [WIDTHB-1:0]        buffer_dout,
  output logic                     buffer_dout_vld,
  output logic                     buffer_full,
  output logic                     buffer_empty,
  output logic [$clog2(UNITS):0]   buffer_count,
  output logic                     buffer_ovf,
  output logic                     buffer_udf
);

  localparam int MINW   = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
  localparam int WUNITS = WIDTHA / MINW;
  localparam int RUNITS = WIDTHB / MINW;
  localparam int AW     = $clog2(UNITS);
  localparam int CW     = AW + 1;

  localparam logic [CW-1:0] W_STEP  = CW'(WUNITS);
  localparam logic [CW-1:0] R_STEP  = CW'(RUNITS);
  localparam logic [CW-1:0] FULL_AT = CW'(UNITS - WUNITS);

  logic [MINW-1:0] mem [UNITS];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            wr_acc;
  logic            rd_acc;

  // The flags come only from the registered count. This keeps the accept
  // decision independent of the other port in the same cycle.
  assign buffer_full  = (buffer_count > FULL_AT);
  assign buffer_empty = (buffer_count < R_STEP);
  assign wr_acc       = buffer_we & ~buffer_full;
  assign rd_acc       = buffer_re & ~buffer_empty;

  // The memory has no reset. Reset rewinds the pointers, so stale data can
  // never be read back. Writes are gated by reset so that a request made in
  // the reset cycle is discarded.
  always_ff @(posedge buffer_clk) begin
    if (!buffer_rst && wr_acc) begin
      for (int i = 0; i < WUNITS; i++) begin
        mem[wr_ptr + AW'(i)] <= buffer_din[WIDTHA-1-i*MINW -: MINW];
      end
    end
  end

  // Pointer, count and read-data path. Each access size divides UNITS, so a
  // wide access never wraps partway through. The natural AW-bit overflow of
  // the pointer gives the modulo-UNITS wrap.
  always_ff @(posedge buffer_clk) begin
    if (buffer_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      buffer_count    <= '0;
      buffer_dout     <= '0;
      buffer_dout_vld <= 1'b0;
    end else begin
      buffer_dout_vld <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(WUNITS);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(RUNITS);
        for (int i = 0; i < RUNITS; i++) begin
          buffer_dout[WIDTHB-1-i*MINW -: MINW] <= mem[rd_ptr + AW'(i)];
        end
      end
      buffer_count <= buffer_count + (wr_acc ? W_STEP : '0)
                                   - (rd_acc ? R_STEP : '0);
    end
  end

`ifdef ASYM_FIFO_ERR_FLAG_EN
  // These flags record a rejected request. Once set, they stay set until reset.
  always_ff @(posedge buffer_clk) begin
    if (buffer_rst) begin
      buffer_ovf <= 1'b0;
      buffer_udf <= 1'b0;
    end else begin
      if (buffer_we && buffer_full) begin
        buffer_ovf <= 1'b1;
      end
      if (buffer_re && buffer_empty) begin
        buffer_udf <= 1'b1;
      end
    end
  end
`else
  assign buffer_ovf = 1'b0;
  assign buffer_udf = 1'b0;
`endif

endmodule
